background_reader: RTL and testbench

- Read-side consumer of the background frame RAM. It turns the VGA controller's DrawX/DrawY scan position into RAM read addresses and fetches 4-bit palette indices. It then converts each index to 24-bit RGB for the colour mapper.
- Supports a per-frame camera scroll offset, so the screen shows a 640x480 window of the larger background image.

---
 rtl/bg_pkg.sv | 43 ++++
 rtl/background_palette.sv | 49 ++++
 rtl/background_reader.sv | 129 ++++++++++++
 tb/tb_background_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// ----------------------------------------------------------------------------
// bg_pkg
// Shared constants and types for the background renderer.
//   - Background image and screen geometry.
//   - Scroll clamp limits.
//   - rgb_t colour type.
//   - 16-entry PALETTE, also used by the sprite colour mapper.
// Optional build macro: BG_WRAP_EN. When it is defined, the x scroll may reach
// BG_W-1, because columns wrap around the image.
// ----------------------------------------------------------------------------
package bg_pkg;

    localparam int BG_W     = 960;
    localparam int BG_H     = 540;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

`ifdef BG_WRAP_EN
    localparam logic [9:0] SX_MAX = 10'(BG_W - 1);
`else
    localparam logic [9:0] SX_MAX = 10'(BG_W - SCREEN_W);
`endif
    localparam logic [9:0] SY_MAX = 10'(BG_H - SCREEN_H);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'h800000, 24'h008000, 24'h808000,
        24'h000080, 24'h800080, 24'h008080, 24'hC0C0C0,
        24'h808080, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
        24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF
    };

    // Saturate a requested scroll offset to its legal maximum
    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/background_palette.sv
// ----------------------------------------------------------------------------
// background_palette
// Registered lookup of a 4-bit palette index into 24-bit RGB.
// Ports:
//   Clk, Reset_n   : clock and synchronous active-low reset
//   i_valid        : i_index belongs to a visible pixel
//   i_index        : palette index read from the background RAM
//   o_rgb          : colour. It is zero when the pixel is not valid.
//   o_transparent  : the index was 0 and the pixel is valid
//   o_valid        : o_rgb belongs to a visible pixel
// ----------------------------------------------------------------------------
module background_palette
    import bg_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       i_valid,
    input  logic [3:0] i_index,
    output rgb_t       o_rgb,
    output logic       o_transparent,
    output logic       o_valid
);

    rgb_t r_rgb;
    logic r_transparent;
    logic r_valid;

    // Colour stage: blanked pixels output black so the mapper never sees stale colour
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rgb         <= 24'h000000;
            r_transparent <= 1'b0;
            r_valid       <= 1'b0;
        end else if (i_valid) begin
            r_rgb         <= PALETTE[i_index];
            r_transparent <= (i_index == 4'd0);
            r_valid       <= 1'b1;
        end else begin
            r_rgb         <= 24'h000000;
            r_transparent <= 1'b0;
            r_valid       <= 1'b0;
        end
    end

    assign o_rgb         = r_rgb;
    assign o_transparent = r_transparent;
    assign o_valid       = r_valid;

endmodule

// File: rtl/background_reader.sv
// ----------------------------------------------------------------------------
// background_reader
// Converts the VGA scan position into background RAM read addresses.
// A per-frame camera scroll offset is applied before the address is formed.
// The 4-bit palette index that the RAM returns is turned into RGB.
// The fixed latency from DrawX/DrawY to RGB is 3 cycles.
// Ports:
//   Clk, Reset_n                  : clock and synchronous active-low reset
//   pix_valid, DrawX, DrawY       : VGA display enable and scan position
//   scroll_we, scroll_x_in/_y_in  : scroll request strobe and offsets
//   read_address                  : registered RAM read address
//   ram_data                      : RAM output, valid one cycle after the address
//   Red, Green, Blue              : pixel colour
//   rgb_valid, transparent        : visible-pixel flag and palette-0 flag
// Optional build macro: BG_WRAP_EN. It enables horizontal wrap-around of
// columns.
// ----------------------------------------------------------------------------
module background_reader
    import bg_pkg::*;
#(
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              scroll_we,
    input  logic [9:0]        scroll_x_in,
    input  logic [9:0]        scroll_y_in,
    output logic [ADDR_W-1:0] read_address,
    input  logic [3:0]        ram_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              rgb_valid,
    output logic              transparent
);

    logic [9:0]        r_sx_shd;
    logic [9:0]        r_sy_shd;
    logic [9:0]        r_sx_act;
    logic [9:0]        r_sy_act;
    logic              r_v0;
    logic              r_v1;
    logic [ADDR_W-1:0] r_read_address;

    logic              w_frame_start;
    logic [9:0]        w_sx_eff;
    logic [9:0]        w_sy_eff;
    logic [10:0]       w_row;
    logic [10:0]       w_col_raw;
    logic [10:0]       w_col;
    logic [ADDR_W-1:0] w_addr;
    rgb_t              w_rgb;

    // Address generation from scan position and frame-stable scroll
    always_comb begin
        w_frame_start = pix_valid && (DrawX == 10'd0) && (DrawY == 10'd0);
        // On the frame-start pixel the shadow is already the value that becomes
        // active. Using it here means pixel (0,0) matches the rest of the frame.
        if (w_frame_start) begin
            w_sx_eff = r_sx_shd;
            w_sy_eff = r_sy_shd;
        end else begin
            w_sx_eff = r_sx_act;
            w_sy_eff = r_sy_act;
        end
        w_row     = {1'b0, DrawY} + {1'b0, w_sy_eff};
        w_col_raw = {1'b0, DrawX} + {1'b0, w_sx_eff};
`ifdef BG_WRAP_EN
        // DrawX < 640 and sx <= 959, so a single subtract is enough to wrap
        if (w_col_raw >= 11'(BG_W)) begin
            w_col = w_col_raw - 11'(BG_W);
        end else begin
            w_col = w_col_raw;
        end
`else
        w_col = w_col_raw;
`endif
        // The sum is formed directly at ADDR_W bits. This gives the same low
        // bits as the wider sum truncated to ADDR_W.
        w_addr = ADDR_W'(w_row) * ADDR_W'(BG_W) + ADDR_W'(w_col);
    end

    // Scroll shadow/active registers, stage-0 address and pipeline valid bits
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sx_shd       <= 10'd0;
            r_sy_shd       <= 10'd0;
            r_sx_act       <= 10'd0;
            r_sy_act       <= 10'd0;
            r_v0           <= 1'b0;
            r_v1           <= 1'b0;
            r_read_address <= '0;
        end else begin
            if (scroll_we) begin
                r_sx_shd <= clamp10(scroll_x_in, SX_MAX);
                r_sy_shd <= clamp10(scroll_y_in, SY_MAX);
            end
            // Non-blocking: a request on this same edge waits for the next frame
            if (w_frame_start) begin
                r_sx_act <= r_sx_shd;
                r_sy_act <= r_sy_shd;
            end
            r_v0 <= pix_valid;
            r_v1 <= r_v0;
            if (pix_valid) begin
                r_read_address <= w_addr;
            end
        end
    end

    background_palette u_palette (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .i_valid       (r_v1),
        .i_index       (ram_data),
        .o_rgb         (w_rgb),
        .o_transparent (transparent),
        .o_valid       (rgb_valid)
    );

    assign read_address = r_read_address;
    assign Red          = w_rgb.r;
    assign Green        = w_rgb.g;
    assign Blue         = w_rgb.b;

endmodule

// File: tb/tb_background_reader.sv
module tb_background_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        scroll_we;
    logic [9:0]  scroll_x;
    logic [9:0]  scroll_y;
    logic [18:0] read_address;
    logic [3:0]  ram_data = 4'd0;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        rgb_valid;
    logic        transparent;

    int total = 0;
    int bad   = 0;

    localparam logic [23:0] PAL [16] = '{
        24'h000000, 24'h800000, 24'h008000, 24'h808000,
        24'h000080, 24'h800080, 24'h008080, 24'hC0C0C0,
        24'h808080, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
        24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF
    };

    typedef struct {
        logic        pv;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [18:0] addr;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    // RAM model: registered read, with contents derived from the address
    function automatic logic [3:0] ram_of(input logic [18:0] a);
        return a[3:0] ^ 4'h8;
    endfunction

    always @(posedge clk) ram_data <= ram_of(read_address);

    background_reader dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .pix_valid    (pix_valid),
        .DrawX        (draw_x),
        .DrawY        (draw_y),
        .scroll_we    (scroll_we),
        .scroll_x_in  (scroll_x),
        .scroll_y_in  (scroll_y),
        .read_address (read_address),
        .ram_data     (ram_data),
        .Red          (red),
        .Green        (green),
        .Blue         (blue),
        .rgb_valid    (rgb_valid),
        .transparent  (transparent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input int x, input int y,
                         input logic we, input int sx, input int sy);
        pix_valid = pv;
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        scroll_we = we;
        scroll_x  = 10'(sx);
        scroll_y  = 10'(sy);
    endtask

    // Check colour outputs for a pixel whose address was addr
    task automatic chk_pix(input string name, input logic pv, input logic [18:0] addr);
        logic [3:0] idx;
        idx = ram_of(addr);
        if (pv) begin
            chk({name, "_valid"}, 32'(rgb_valid), 32'd1);
            chk({name, "_rgb"}, {8'd0, red, green, blue}, {8'd0, PAL[idx]});
            chk({name, "_transp"}, 32'(transparent), 32'(idx == 4'd0));
        end else begin
            chk({name, "_valid"}, 32'(rgb_valid), 32'd0);
            chk({name, "_rgb"}, {8'd0, red, green, blue}, 32'd0);
            chk({name, "_transp"}, 32'(transparent), 32'd0);
        end
    endtask

    initial begin
        int n_blank;
        logic pv_now;
        logic pv_old;

        // Active scroll (10,3)
        tbl[0] = '{1'b1, 10'd5,   10'd2,   19'd4815};
        tbl[1] = '{1'b1, 10'd14,  10'd0,   19'd2904};
        tbl[2] = '{1'b0, 10'd100, 10'd100, 19'd2904};
        tbl[3] = '{1'b1, 10'd639, 10'd479, 19'd463369};
        tbl[4] = '{1'b1, 10'd1,   10'd0,   19'd2891};
        tbl[5] = '{1'b1, 10'd0,   10'd1,   19'd3850};

        // Reset held with visible pixels at frame start
        rst_n = 1'b0;
        drive(1'b1, 0, 0, 1'b0, 0, 0);
        repeat (4) step();
        chk("rst_addr", 32'(read_address), 32'd0);
        chk("rst_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("rst_valid", 32'(rgb_valid), 32'd0);
        chk("rst_transp", 32'(transparent), 32'd0);

        // First rgb_valid exactly three edges after release
        rst_n = 1'b1;
        step();
        chk("rel_valid_1", 32'(rgb_valid), 32'd0);
        chk("rel_addr", 32'(read_address), 32'd0);
        drive(1'b0, 0, 0, 1'b0, 0, 0);
        step();
        chk("rel_valid_2", 32'(rgb_valid), 32'd0);
        step();
        chk_pix("rel_first", 1'b1, 19'd0);
        step();
        chk("rel_valid_4", 32'(rgb_valid), 32'd0);

        // Scroll (10,3) then frame start, then table vectors
        drive(1'b0, 0, 0, 1'b1, 10, 3);
        step();
        drive(1'b1, 0, 0, 1'b0, 0, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(tbl[i].pv, int'(tbl[i].x), int'(tbl[i].y), 1'b0, 0, 0);
            else       drive(1'b0, 0, 0, 1'b0, 0, 0);
            step();
            if (i < 6)  chk("tbl_addr", 32'(read_address), 32'(tbl[i].addr));
            if (i >= 2) chk_pix("tbl_pix", tbl[i-2].pv, tbl[i-2].addr);
        end

        // Clamp: oversized request, corner pixel
        drive(1'b0, 0, 0, 1'b1, 900, 500);
        step();
        drive(1'b1, 0, 0, 1'b0, 0, 0);
        step();
        drive(1'b1, 639, 479, 1'b0, 0, 0);
        step();
`ifdef BG_WRAP_EN
        chk("clamp_addr", 32'(read_address), 32'd518019);
`else
        chk("clamp_addr", 32'(read_address), 32'd518399);
`endif
        drive(1'b0, 0, 0, 1'b0, 0, 0);
        step();
        step();
`ifdef BG_WRAP_EN
        chk_pix("clamp_pix", 1'b1, 19'd518019);
`else
        chk_pix("clamp_pix", 1'b1, 19'd518399);
`endif

        // Deferred scroll: mid-frame writes (last wins) do not touch this frame
        drive(1'b1, 5, 5, 1'b1, 200, 1);
        step();
`ifdef BG_WRAP_EN
        chk("defer_mid1", 32'(read_address), 32'd63305);
`else
        chk("defer_mid1", 32'(read_address), 32'd62725);
`endif
        drive(1'b1, 6, 5, 1'b1, 40, 0);
        step();
`ifdef BG_WRAP_EN
        chk("defer_mid2", 32'(read_address), 32'd63306);
`else
        chk("defer_mid2", 32'(read_address), 32'd62726);
`endif
        // Request coincident with frame start: old shadow (40,0) goes active
        drive(1'b1, 0, 0, 1'b1, 100, 10);
        step();
        drive(1'b1, 5, 5, 1'b0, 0, 0);
        step();
        chk("defer_next", 32'(read_address), 32'd4845);
        drive(1'b1, 0, 0, 1'b0, 0, 0);
        step();
        drive(1'b1, 5, 5, 1'b0, 0, 0);
        step();
        chk("defer_after", 32'(read_address), 32'd14505);

        // Blanking: 160 invisible cycles framed by visible pixels
        n_blank = 0;
        for (int c = 0; c < 170; c++) begin
            pv_now = (c < 3) || (c >= 163);
            drive(pv_now, c, 7, 1'b0, 0, 0);
            step();
            if (c >= 2) begin
                pv_old = ((c - 2) < 3) || ((c - 2) >= 163);
                chk("blank_valid", 32'(rgb_valid), 32'(pv_old));
                if (!pv_old) chk("blank_rgb", {8'd0, red, green, blue}, 32'd0);
                if (!rgb_valid) n_blank++;
            end
        end
        chk("blank_len", 32'(n_blank), 32'd160);

`ifdef BG_WRAP_EN
        // Horizontal wrap-around
        drive(1'b0, 0, 0, 1'b1, 900, 0);
        step();
        drive(1'b1, 0, 0, 1'b0, 0, 0);
        step();
        drive(1'b1, 100, 0, 1'b0, 0, 0);
        step();
        chk("wrap_100", 32'(read_address), 32'd40);
        drive(1'b1, 59, 0, 1'b0, 0, 0);
        step();
        chk("wrap_59", 32'(read_address), 32'd959);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
